// File: rtl/io_pkg.sv
// io_pkg: shared constants and FSM encoding for the dmem I/O byte streamer
package io_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0000_03FC;
    localparam int BYTES_PER_WORD = 4;
    // Word-address match; byte lanes [1:0] are masked so every bit of addr is consumed
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] io_addr);
        return (addr & 32'hFFFF_FFFC) == (io_addr & 32'hFFFF_FFFC);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO with count; a push on full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/dmem_io_streamer.sv
// dmem_io_streamer: queues stores to the I/O word and streams them LSB-first onto the byte pins
module dmem_io_streamer
    import io_pkg::*;
#(
    parameter logic [31:0] IO_ADDR    = IO_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              dmem_write,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_wdata,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              out_active,
    output logic              fifo_full,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int IW = $clog2(BYTES_PER_WORD);
    logic [0:0] state;
    logic [31:0] sreg, head;
    logic [IW-1:0] idx;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic hit, push, pop, empty, last;
    assign hit  = dmem_write && addr_hit(dmem_addr, IO_ADDR);
    assign last = idx == IW'(BYTES_PER_WORD - 1);
    // IDLE pops whenever data waits; SEND only on the tick that emits the final byte
    assign pop  = !empty && (state == ST_IDLE || (tick && last));
    assign push = hit && (!fifo_full || pop);
    assign out_active = state == ST_SEND;
    assign busy = (count != '0) || state != ST_IDLE;
    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (dmem_wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            idx       <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (!empty) begin
                    sreg  <= head;
                    idx   <= '0;
                    state <= ST_SEND;
                end else if (tick) begin
                    out_byte <= 8'h00;
                end
            end else if (tick) begin
                out_byte  <= sreg[7:0];
                out_valid <= 1'b1;
                if (last) begin
                    idx <= '0;
                    if (!empty) sreg <= head;
                    else state <= ST_IDLE;
                end else begin
                    sreg <= sreg >> 8;
                    idx  <= idx + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (hit && fifo_full && !pop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_dmem_io_streamer.sv
// tb_dmem_io_streamer: scoreboard bench; expected bytes queued at each accepted store
module tb_dmem_io_streamer;
    logic clk = 1'b0, rst_n, tick, dmem_write;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [7:0] out_byte, drop_cnt;
    logic out_valid, out_active, fifo_full, busy;
    logic tick_en, manual_tick;
    logic [7:0] exp_q [$];
    int n_cmp = 0, n_err = 0, n_bytes = 0, gaps;
    dmem_io_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .dmem_write (dmem_write),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_active (out_active),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    // Tick changes on the falling edge so it is stable across exactly one rising edge
    initial begin
        int div = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                div = (div == 7) ? 0 : div + 1;
                tick = (div == 0);
            end else begin
                tick = manual_tick;
            end
        end
    end
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                n_bytes++;
                if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
                else check("byte", {24'h0, out_byte}, {24'h0, exp_q.pop_front()});
            end
        end
    end
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit acc);
        dmem_write = 1'b1;
        dmem_addr  = a;
        dmem_wdata = d;
        if (acc) for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
        @(posedge clk); #1;
        dmem_write = 1'b0;
    endtask
    task automatic drain(input int maxc);
        int nb0 = n_bytes;
        gaps = 0;
        for (int c = 0; c < maxc && exp_q.size() != 0; c++) begin
            @(negedge clk); #1;
            if (n_bytes > nb0 && exp_q.size() != 0 && !out_active) gaps++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("active_gaps", 32'(gaps), 32'd0);
        check("busy_end", {31'h0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask
    task automatic mtick();
        manual_tick = 1'b1;
        @(posedge clk); #1;
        manual_tick = 1'b0;
        @(posedge clk); #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int nb0;
        rst_n = 1'b0; tick_en = 1'b0; manual_tick = 1'b0;
        dmem_write = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_byte", {24'h0, out_byte}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_active", {31'h0, out_active}, 32'h0);
        check("rst_full", {31'h0, fifo_full}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_drop", {24'h0, drop_cnt}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick_en = 1'b1;
        wr(32'h0000_03FC, 32'hA1B2C3D4, 1'b1);
        drain(200);
        repeat (10) @(posedge clk); #1;
        check("idle_zero", {24'h0, out_byte}, 32'h0);
        wr(32'h0000_03F8, 32'h5566_7788, 1'b0);
        wr(32'h0000_0000, 32'h99AA_BBCC, 1'b0);
        wr(32'h0000_03FE, 32'h1122_3344, 1'b1);
        drain(200);
        check("filter_drop", {24'h0, drop_cnt}, 32'h0);
        tick_en = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) wr(32'h0000_03FC, 32'(i), i <= 5);
        check("ovf_full", {31'h0, fifo_full}, 32'h1);
        check("ovf_drop", {24'h0, drop_cnt}, 32'h1);
        tick_en = 1'b1;
        drain(400);
        check("ovf_full_after", {31'h0, fifo_full}, 32'h0);
        wr(32'h0000_03FC, 32'h0000_00FF, 1'b1);
        wr(32'h0000_03FC, 32'h0000_FF00, 1'b1);
        drain(300);
        tick_en = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) wr(32'h0000_03FC, 32'h1111_1111 * i, 1'b1);
        check("fp_full", {31'h0, fifo_full}, 32'h1);
        repeat (3) mtick();
        manual_tick = 1'b1;
        wr(32'h0000_03FC, 32'h6666_6666, 1'b1);
        manual_tick = 1'b0;
        check("fp_drop", {24'h0, drop_cnt}, 32'h1);
        check("fp_full_kept", {31'h0, fifo_full}, 32'h1);
        tick_en = 1'b1;
        drain(600);
        wr(32'h0000_03FC, 32'hCAFE_BABE, 1'b1);
        nb0 = n_bytes;
        for (int c = 0; c < 100 && n_bytes < nb0 + 2; c++) begin
            @(negedge clk); #2;
        end
        check("rst_wait", 32'(n_bytes - nb0), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_byte", {24'h0, out_byte}, 32'h0);
        check("mid_valid", {31'h0, out_valid}, 32'h0);
        check("mid_active", {31'h0, out_active}, 32'h0);
        check("mid_busy", {31'h0, busy}, 32'h0);
        check("mid_drop", {24'h0, drop_cnt}, 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        nb0 = n_bytes;
        repeat (40) @(posedge clk); #1;
        check("post_rst_bytes", 32'(n_bytes - nb0), 32'd0);
        check("post_rst_byte", {24'h0, out_byte}, 32'h0);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
